// File: rtl/axi4lite_coeff_regs_if.sv
// AXI4-Lite bus bundle between the system interconnect (master) and the
// FIR coefficient register block (slave).
interface axi4lite_coeff_regs_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   s_awaddr;
    logic                    s_awvalid;
    logic                    s_awready;
    logic [DATA_WIDTH-1:0]   s_wdata;
    logic [DATA_WIDTH/8-1:0] s_wstrb;
    logic                    s_wvalid;
    logic                    s_wready;
    logic [1:0]              s_bresp;
    logic                    s_bvalid;
    logic                    s_bready;
    logic [ADDR_WIDTH-1:0]   s_araddr;
    logic                    s_arvalid;
    logic                    s_arready;
    logic [DATA_WIDTH-1:0]   s_rdata;
    logic [1:0]              s_rresp;
    logic                    s_rvalid;
    logic                    s_rready;

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        output s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid,
        input  s_arready, s_rdata, s_rresp, s_rvalid
    );

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        input  s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid,
        output s_arready, s_rdata, s_rresp, s_rvalid
    );
endinterface

// File: rtl/axi4lite_coeff_regs.sv
// AXI4-Lite register slave holding the FIR coefficient bank plus CTRL/STATUS;
// drives the coefficients, filter enable and a one-cycle coefficient-load strobe.
module axi4lite_coeff_regs #(
    parameter int AXI4LITE_ADDR_WIDTH = 32,
    parameter int AXI4LITE_DATA_WIDTH = 32,
    parameter int NOF_COEFF           = 12,
    parameter int DATA_WIDTH          = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    axi4lite_coeff_regs_if.slave            s_axi,
    output logic [NOF_COEFF*DATA_WIDTH-1:0] coeff_o,
    output logic                            filter_en_o,
    output logic                            coeff_load_o,
    input  logic                            filter_busy_i
);

    localparam int         STRB_WIDTH  = AXI4LITE_DATA_WIDTH / 8;
    localparam logic [5:0] CTRL_IDX    = 6'(NOF_COEFF);
    localparam logic [5:0] STATUS_IDX  = 6'(NOF_COEFF + 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    function automatic logic [AXI4LITE_DATA_WIDTH-1:0] sext_coeff(input logic [DATA_WIDTH-1:0] c);
        return {{(AXI4LITE_DATA_WIDTH-DATA_WIDTH){c[DATA_WIDTH-1]}}, c};
    endfunction

    function automatic logic [1:0] decode_resp(input logic [5:0] idx);
        return (idx <= STATUS_IDX) ? RESP_OKAY : RESP_SLVERR;
    endfunction

    // register bank
    logic [DATA_WIDTH-1:0] r_coeff [NOF_COEFF];
    logic                  r_enable;
    logic                  r_coeff_load;

    // write channel
    w_state_t              r_w_state;
    w_state_t              w_w_state_nxt;
    logic                  r_awready, w_awready_nxt;
    logic                  r_wready,  w_wready_nxt;
    logic                  r_aw_done, w_aw_done_nxt;
    logic                  r_w_done,  w_w_done_nxt;
    logic                  r_bvalid,  w_bvalid_nxt;
    logic [1:0]            r_bresp,   w_bresp_nxt;
    logic [5:0]            r_awidx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_wstrb0;
    logic                  w_aw_hs, w_w_hs, w_have_aw, w_have_w;
    logic [5:0]            w_wr_idx;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic                  w_wr_strb0;
    logic                  w_wr_en;

    // read channel
    r_state_t                       r_r_state;
    r_state_t                       w_r_state_nxt;
    logic                           r_arready, w_arready_nxt;
    logic                           r_rvalid,  w_rvalid_nxt;
    logic [AXI4LITE_DATA_WIDTH-1:0] r_rdata,   w_rdata_nxt;
    logic [1:0]                     r_rresp,   w_rresp_nxt;
    logic                           w_ar_hs;
    logic [5:0]                     w_rd_idx;
    logic [AXI4LITE_DATA_WIDTH-1:0] w_rd_data;
    logic [1:0]                     w_rd_resp;

    logic w_unused_bits;
    assign w_unused_bits = ^{s_axi.s_awaddr[AXI4LITE_ADDR_WIDTH-1:8], s_axi.s_awaddr[1:0],
                             s_axi.s_araddr[AXI4LITE_ADDR_WIDTH-1:8], s_axi.s_araddr[1:0],
                             s_axi.s_wdata[AXI4LITE_DATA_WIDTH-1:DATA_WIDTH],
                             s_axi.s_wstrb[STRB_WIDTH-1:1]};

    // Write channel next-state: AW and W may arrive in any order; the write fires once both are held.
    always_comb begin
        w_aw_hs       = s_axi.s_awvalid & r_awready;
        w_w_hs        = s_axi.s_wvalid & r_wready;
        w_have_aw     = r_aw_done | w_aw_hs;
        w_have_w      = r_w_done | w_w_hs;
        w_wr_idx      = w_aw_hs ? s_axi.s_awaddr[7:2] : r_awidx;
        w_wr_data     = w_w_hs ? s_axi.s_wdata[DATA_WIDTH-1:0] : r_wdata;
        w_wr_strb0    = w_w_hs ? s_axi.s_wstrb[0] : r_wstrb0;
        w_wr_en       = 1'b0;
        w_w_state_nxt = r_w_state;
        w_awready_nxt = r_awready;
        w_wready_nxt  = r_wready;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        w_bvalid_nxt  = r_bvalid;
        w_bresp_nxt   = r_bresp;
        case (r_w_state)
            W_IDLE: begin
                if (w_have_aw && w_have_w) begin
                    w_wr_en       = 1'b1;
                    w_w_state_nxt = W_RESP;
                    w_awready_nxt = 1'b0;
                    w_wready_nxt  = 1'b0;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                    w_bvalid_nxt  = 1'b1;
                    w_bresp_nxt   = decode_resp(w_wr_idx);
                end else begin
                    w_awready_nxt = ~w_have_aw;
                    w_wready_nxt  = ~w_have_w;
                    w_aw_done_nxt = w_have_aw;
                    w_w_done_nxt  = w_have_w;
                end
            end
            W_RESP: begin
                if (s_axi.s_bready) begin
                    w_w_state_nxt = W_IDLE;
                    w_bvalid_nxt  = 1'b0;
                    w_awready_nxt = 1'b1;
                    w_wready_nxt  = 1'b1;
                end else begin
                    w_w_state_nxt = W_RESP;
                end
            end
            default: begin
                w_w_state_nxt = W_IDLE;
                w_bvalid_nxt  = 1'b0;
            end
        endcase
    end

    // Write channel state and handshake registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_w_state <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_awidx   <= 6'd0;
            r_wdata   <= '0;
            r_wstrb0  <= 1'b0;
        end else begin
            r_w_state <= w_w_state_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_aw_done <= w_aw_done_nxt;
            r_w_done  <= w_w_done_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_bresp   <= w_bresp_nxt;
            r_awidx   <= w_wr_idx;
            r_wdata   <= w_wr_data;
            r_wstrb0  <= w_wr_strb0;
        end
    end

    // Register bank update; every writable field lives in byte 0, so only wstrb[0] matters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NOF_COEFF; k++) begin
                r_coeff[k] <= '0;
            end
            r_enable     <= 1'b0;
            r_coeff_load <= 1'b0;
        end else begin
            r_coeff_load <= 1'b0;
            if (w_wr_en && w_wr_strb0) begin
                for (int k = 0; k < NOF_COEFF; k++) begin
                    if (w_wr_idx == 6'(k)) begin
                        r_coeff[k] <= w_wr_data;
                    end
                end
                if (w_wr_idx == CTRL_IDX) begin
                    r_enable     <= w_wr_data[0];
                    r_coeff_load <= w_wr_data[1];
                end
            end
        end
    end

    // Read data mux over the current (pre-write) register contents.
    always_comb begin
        w_ar_hs   = s_axi.s_arvalid & r_arready;
        w_rd_idx  = s_axi.s_araddr[7:2];
        w_rd_data = '0;
        w_rd_resp = decode_resp(w_rd_idx);
        if (w_rd_idx < CTRL_IDX) begin
            for (int k = 0; k < NOF_COEFF; k++) begin
                w_rd_data = (w_rd_idx == 6'(k)) ? sext_coeff(r_coeff[k]) : w_rd_data;
            end
        end else if (w_rd_idx == CTRL_IDX) begin
            w_rd_data = {{(AXI4LITE_DATA_WIDTH-1){1'b0}}, r_enable};
        end else if (w_rd_idx == STATUS_IDX) begin
            w_rd_data = {{(AXI4LITE_DATA_WIDTH-1){1'b0}}, filter_busy_i};
        end else begin
            w_rd_data = '0;
        end
    end

    // Read channel next-state: one outstanding read, data held until accepted.
    always_comb begin
        w_r_state_nxt = r_r_state;
        w_arready_nxt = r_arready;
        w_rvalid_nxt  = r_rvalid;
        w_rdata_nxt   = r_rdata;
        w_rresp_nxt   = r_rresp;
        case (r_r_state)
            R_IDLE: begin
                if (w_ar_hs) begin
                    w_r_state_nxt = R_DATA;
                    w_arready_nxt = 1'b0;
                    w_rvalid_nxt  = 1'b1;
                    w_rdata_nxt   = w_rd_data;
                    w_rresp_nxt   = w_rd_resp;
                end else begin
                    w_arready_nxt = 1'b1;
                end
            end
            R_DATA: begin
                if (s_axi.s_rready) begin
                    w_r_state_nxt = R_IDLE;
                    w_rvalid_nxt  = 1'b0;
                    w_arready_nxt = 1'b1;
                end else begin
                    w_r_state_nxt = R_DATA;
                end
            end
            default: begin
                w_r_state_nxt = R_IDLE;
                w_rvalid_nxt  = 1'b0;
            end
        endcase
    end

    // Read channel state and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_r_state <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            r_r_state <= w_r_state_nxt;
            r_arready <= w_arready_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rdata   <= w_rdata_nxt;
            r_rresp   <= w_rresp_nxt;
        end
    end

    // Flatten the coefficient registers onto the parallel bank output.
    always_comb begin
        coeff_o = '0;
        for (int k = 0; k < NOF_COEFF; k++) begin
            coeff_o[k*DATA_WIDTH +: DATA_WIDTH] = r_coeff[k];
        end
    end

    assign filter_en_o     = r_enable;
    assign coeff_load_o    = r_coeff_load;
    assign s_axi.s_awready = r_awready;
    assign s_axi.s_wready  = r_wready;
    assign s_axi.s_bvalid  = r_bvalid;
    assign s_axi.s_bresp   = r_bresp;
    assign s_axi.s_arready = r_arready;
    assign s_axi.s_rvalid  = r_rvalid;
    assign s_axi.s_rdata   = r_rdata;
    assign s_axi.s_rresp   = r_rresp;

endmodule

// File: tb/tb_axi4lite_coeff_regs.sv
// Randomized self-checking bench for axi4lite_coeff_regs against an
// array-based register-map model.
module tb_axi4lite_coeff_regs;

    logic        clk;
    logic        rst;
    logic [95:0] coeff_o;
    logic        filter_en_o;
    logic        coeff_load_o;
    logic        filter_busy_i;

    int n_checks;
    int n_fail;

    axi4lite_coeff_regs_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi4lite_coeff_regs #(
        .AXI4LITE_ADDR_WIDTH(32),
        .AXI4LITE_DATA_WIDTH(32),
        .NOF_COEFF(12),
        .DATA_WIDTH(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axi        (bus.slave),
        .coeff_o      (coeff_o),
        .filter_en_o  (filter_en_o),
        .coeff_load_o (coeff_load_o),
        .filter_busy_i(filter_busy_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: coefficient values as plain integers 0..255
    int unsigned m_coeff [12];
    bit          m_en;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int reg_idx(input logic [31:0] addr);
        return int'((addr / 32'd4) % 32'd64);
    endfunction

    function automatic logic [31:0] m_rd(input logic [31:0] addr, input bit busy);
        int idx = reg_idx(addr);
        if (idx < 12) begin
            if (m_coeff[idx] >= 128) return m_coeff[idx] + 32'hFFFF_FF00;
            else return m_coeff[idx];
        end
        if (idx == 12) return m_en ? 32'd1 : 32'd0;
        if (idx == 13) return busy ? 32'd1 : 32'd0;
        return 32'd0;
    endfunction

    function automatic logic [1:0] m_resp(input logic [31:0] addr);
        return (reg_idx(addr) <= 13) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [95:0] m_bank();
        logic [95:0] v = 96'd0;
        for (int k = 0; k < 12; k++) v = v | (96'(m_coeff[k]) << (8 * k));
        return v;
    endfunction

    function automatic bit m_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int idx = reg_idx(addr);
        bit load = 1'b0;
        if (strb[0]) begin
            if (idx < 12) m_coeff[idx] = data % 32'd256;
            else if (idx == 12) begin
                m_en = data[0];
                load = data[1];
            end
        end
        return load;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 12; k++) m_coeff[k] = 0;
        m_en = 1'b0;
    endtask

    // Issue one write; called and returns at a negative clock edge.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done = 1'b0;
        bit w_done = 1'b0;
        bit aw_fire, w_fire, exp_load;
        logic [1:0] exp_resp;
        int cyc = 0;
        bus.s_awaddr = addr;
        bus.s_wdata  = data;
        bus.s_wstrb  = strb;
        while (!(aw_done && w_done) && cyc < 64) begin
            bus.s_awvalid = !aw_done && (cyc >= aw_dly);
            bus.s_wvalid  = !w_done && (cyc >= w_dly);
            check_eq("b_early", bus.s_bvalid, 1'b0);
            aw_fire = bus.s_awvalid && bus.s_awready;
            w_fire  = bus.s_wvalid && bus.s_wready;
            @(posedge clk);
            aw_done = aw_done | aw_fire;
            w_done  = w_done | w_fire;
            cyc++;
            @(negedge clk);
        end
        bus.s_awvalid = 1'b0;
        bus.s_wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            check_eq("wr_timeout", 1'b0, 1'b1);
            return;
        end
        exp_load = m_write(addr, data, strb);
        exp_resp = m_resp(addr);
        check_eq("bvalid_lat", bus.s_bvalid, 1'b1);
        check_eq("bresp", bus.s_bresp, exp_resp);
        check_eq("coeff_o", coeff_o, m_bank());
        check_eq("filter_en", filter_en_o, m_en);
        check_eq("load_pulse", coeff_load_o, exp_load);
        for (int i = 0; i < b_dly; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("bvalid_hold", bus.s_bvalid, 1'b1);
            check_eq("bresp_hold", bus.s_bresp, exp_resp);
            check_eq("awready_resp", {bus.s_awready, bus.s_wready}, 2'b00);
            check_eq("load_one_cyc", coeff_load_o, 1'b0);
        end
        bus.s_bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.s_bready = 1'b0;
        check_eq("bvalid_clr", bus.s_bvalid, 1'b0);
        check_eq("load_clr", coeff_load_o, 1'b0);
    endtask

    // Issue one read and compare with the model captured at the AR handshake.
    task automatic axi_read(input logic [31:0] addr, input int ar_dly, input int r_dly);
        bit fired = 1'b0;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        int cyc = 0;
        exp_data = 32'd0;
        exp_resp = 2'b00;
        bus.s_araddr = addr;
        while (!fired && cyc < 64) begin
            bus.s_arvalid = (cyc >= ar_dly);
            filter_busy_i = 1'($urandom_range(0, 1));
            fired = bus.s_arvalid && bus.s_arready;
            exp_data = m_rd(addr, filter_busy_i);
            exp_resp = m_resp(addr);
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        bus.s_arvalid = 1'b0;
        if (!fired) begin
            check_eq("rd_timeout", 1'b0, 1'b1);
            return;
        end
        check_eq("rvalid_lat", bus.s_rvalid, 1'b1);
        check_eq("rdata", bus.s_rdata, exp_data);
        check_eq("rresp", bus.s_rresp, exp_resp);
        for (int i = 0; i < r_dly; i++) begin
            filter_busy_i = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            check_eq("rdata_hold", bus.s_rdata, exp_data);
            check_eq("rvalid_hold", {bus.s_rvalid, bus.s_arready}, 2'b10);
        end
        bus.s_rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.s_rready = 1'b0;
        check_eq("rvalid_clr", bus.s_rvalid, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        m_reset();
        rst = 1'b1;
        filter_busy_i = 1'b0;
        bus.s_awaddr = 32'd0; bus.s_awvalid = 1'b0;
        bus.s_wdata = 32'd0;  bus.s_wstrb = 4'd0; bus.s_wvalid = 1'b0;
        bus.s_bready = 1'b0;
        bus.s_araddr = 32'd0; bus.s_arvalid = 1'b0; bus.s_rready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", {bus.s_awready, bus.s_wready, bus.s_arready}, 3'b000);
        check_eq("rst_valid", {bus.s_bvalid, bus.s_rvalid, coeff_load_o, filter_en_o}, 4'b0000);
        check_eq("rst_resp", {bus.s_bresp, bus.s_rresp, bus.s_rdata}, 36'd0);
        check_eq("rst_coeff", coeff_o, 96'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("ready_after_rst", {bus.s_awready, bus.s_wready, bus.s_arready}, 3'b111);

        for (int k = 0; k < 14; k++) axi_read(32'(k * 4), 0, 0);

        axi_write(32'h08, 32'hFFFF_FF85, 4'h1, 0, 0, 0);
        check_eq("coeff2_byte", coeff_o[23:16], 8'h85);
        axi_read(32'h08, 0, 0);

        axi_write(32'h14, 32'h0000_005A, 4'h1, 3, 0, 4);
        axi_write(32'h30, 32'h0000_0003, 4'h1, 0, 0, 1);
        axi_read(32'h30, 0, 0);

        axi_write(32'h40, 32'h0000_00FF, 4'hF, 0, 0, 0);
        axi_read(32'h38, 0, 0);
        axi_write(32'h00, 32'h0000_007F, 4'h0, 0, 0, 0);
        axi_read(32'h00, 0, 0);
        axi_write(32'h34, 32'h0000_0001, 4'hF, 0, 1, 0);

        axi_write(32'h04, 32'h0000_0011, 4'h1, 0, 0, 0);
        fork
            axi_write(32'h04, 32'h0000_0022, 4'h1, 0, 0, 0);
            axi_read(32'h04, 0, 0);
        join
        axi_read(32'h04, 0, 0);

        for (int it = 0; it < 80; it++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 17) * 4 + $urandom_range(0, 3));
            axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            a = 32'($urandom_range(0, 17) * 4 + $urandom_range(0, 3));
            axi_read(a, $urandom_range(0, 2), $urandom_range(0, 2));
        end

        // reset while a write response is pending
        axi_write(32'h1C, 32'h0000_00C3, 4'h1, 0, 0, 0);
        bus.s_awaddr = 32'h10; bus.s_wdata = 32'h0000_0077; bus.s_wstrb = 4'h1;
        bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        check_eq("bvalid_pending", bus.s_bvalid, 1'b1);
        rst = 1'b1;
        m_reset();
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_drops_b", bus.s_bvalid, 1'b0);
        check_eq("rst_clears_bank", coeff_o, m_bank());
        check_eq("rst_clears_en", filter_en_o, m_en);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("ready_after_rst2", {bus.s_awready, bus.s_wready, bus.s_arready, bus.s_bvalid}, 4'b1110);
        axi_read(32'h10, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
